mine_placer: RTL

Sequences mine placement for the 8x8 minesweeper board. On `start` it clears the board, then draws random coordinates from the board's random source. Each free cell drawn receives a mine until `total_mines` are placed; the player's safe cell is never mined. The resulting `mine_map` is the board's mine layer, consumed by the game FSM and the display/neighbour-count logic.

---
 rtl/mine_placer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mine_placer.sv
// Places total_mines mines on the 8x8 board from a random coordinate source, never on the safe cell.
// Latency: done rises k+2 cycles after an accepted start in the best case; 2 cycles for total 0.
// No backpressure: start is only accepted in IDLE or DONE; pulses while busy are dropped.
module mine_placer #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int MAX_TRIES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           total_mines,
    input  logic [2:0]           safe_row,
    input  logic [2:0]           safe_col,
    input  logic [2:0]           random_row,
    input  logic [2:0]           random_col,
    output logic [ROWS*COLS-1:0] mine_map,
    output logic [3:0]           mines_placed,
    output logic                 busy,
    output logic                 done,
    output logic                 fallback
);

    localparam logic [7:0] TRIES_LIM = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ROWS*COLS-1:0]  map_q, map_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [7:0]            tries_q, tries_d;
    logic [5:0]            scan_q, scan_d;
    logic [3:0]            total_q, total_d;
    logic [5:0]            safe_q, safe_d;
    logic                  fb_q, fb_d;
    logic [5:0]            draw_idx;

    // Next-state and datapath: one placement attempt per cycle in DRAW or SCAN.
    always_comb begin
        state_d  = state_q;
        map_d    = map_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        scan_d   = scan_q;
        total_d  = total_q;
        safe_d   = safe_q;
        fb_d     = fb_q;
        draw_idx = {random_row, random_col};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    total_d = total_mines;
                    safe_d  = {safe_row, safe_col};
                    fb_d    = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                map_d   = '0;
                cnt_d   = '0;
                tries_d = '0;
                scan_d  = '0;
                state_d = (total_q == 4'd0) ? ST_DONE : ST_DRAW;
            end
            ST_DRAW: begin
                tries_d = tries_q + 8'd1;
                if (!map_q[draw_idx] && (draw_idx != safe_q)) begin
                    map_d[draw_idx] = 1'b1;
                    cnt_d           = cnt_q + 4'd1;
                end
                // Completing the board wins over running out of tries on the same draw.
                if (cnt_d == total_q) begin
                    state_d = ST_DONE;
                end else if (tries_d == TRIES_LIM) begin
                    state_d = ST_SCAN;
                    fb_d    = 1'b1;
                    scan_d  = '0;
                end
            end
            ST_SCAN: begin
                if (!map_q[scan_q] && (scan_q != safe_q)) begin
                    map_d[scan_q] = 1'b1;
                    cnt_d         = cnt_q + 4'd1;
                end
                scan_d = scan_q + 6'd1;
                if (cnt_d == total_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            map_q   <= '0;
            cnt_q   <= '0;
            tries_q <= '0;
            scan_q  <= '0;
            total_q <= '0;
            safe_q  <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            scan_q  <= scan_d;
            total_q <= total_d;
            safe_q  <= safe_d;
            fb_q    <= fb_d;
        end
    end

    assign mine_map     = map_q;
    assign mines_placed = cnt_q;
    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_DRAW) || (state_q == ST_SCAN);
    assign done         = (state_q == ST_DONE);
    assign fallback     = fb_q;

endmodule
